// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states, access-size helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] op_size(input lsu_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
            default:              op_size = 3'd4;
        endcase
    endfunction

    function automatic logic op_is_store(input lsu_op_e op);
        op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: big-endian load extraction/extension and SB/SH read-modify-write merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        load_data = rd_word;
        case (op)
            OP_LB:   load_data = {{24{rd_word[31]}}, rd_word[31:24]};
            OP_LBU:  load_data = {24'h0, rd_word[31:24]};
            OP_LH:   load_data = {{16{rd_word[31]}}, rd_word[31:16]};
            OP_LHU:  load_data = {16'h0, rd_word[31:16]};
            default: load_data = rd_word;
        endcase
    end

    // The addressed byte/half sits in the top lane; the remaining bytes are written back unchanged.
    always_comb begin
        merge_data = wdata;
        case (op)
            OP_SB:   merge_data = {wdata[7:0], rd_word[23:0]};
            OP_SH:   merge_data = {wdata[15:0], rd_word[15:0]};
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a byte-addressed, 4-byte-write datamem.
// Optional macro LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses with resp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] data_addr,
    output logic        data_wr,
    output logic [31:0] data_out,
    input  logic [31:0] data_in
);

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_out_q, data_out_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;

    lsu_op_e     req_op_e;
    logic [32:0] req_end;
    logic        range_err;
    logic        misalign;
    logic        accept;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign req_op_e  = lsu_op_e'(req_op);
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // 33-bit end address so requests near 2^32 cannot wrap past the range check.
    assign req_end   = {1'b0, req_addr} + {30'h0, op_size(req_op_e)};
    assign range_err = req_end > 33'(MEM_BYTES);

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (req_op_e)
            OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
            OP_LW, OP_SW:         misalign = |req_addr[1:0];
            default:              misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .op         (op_q),
        .rd_word    (data_in),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_out_d   = data_out_q;
        resp_rdata_d = resp_rdata_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = req_op_e;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (range_err || misalign) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_op_e == OP_SW) begin
                        state_d    = WR;
                        data_out_d = req_wdata;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (op_is_store(op_q)) begin
                    state_d    = WR;
                    data_out_d = merge_data;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_data;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_LB;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_out_q   <= '0;
            resp_rdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_out_q   <= data_out_d;
            resp_rdata_q <= resp_rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign data_wr    = (state_q == WR) && !rst;
    assign data_addr  = addr_q;
    assign data_out   = data_out_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a behavioural 1 KiB big-endian datamem with a response scoreboard.
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 1024;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB  = 3'd5, SH = 3'd6, SW  = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_addr;
    logic        data_wr;
    logic [31:0] data_out;
    logic [31:0] data_in;

    logic [7:0]  mem [0:MEM_BYTES-1];
    int          wr_count = 0;
    logic [31:0] last_wr = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .data_addr  (data_addr),
        .data_wr    (data_wr),
        .data_out   (data_out),
        .data_in    (data_in)
    );

    // Bytes past the end of memory read as zero and are dropped on write.
    always_comb begin
        data_in = '0;
        for (int i = 0; i < 4; i++)
            if (({1'b0, data_addr} + 33'(i)) < 33'(MEM_BYTES))
                data_in[31-8*i -: 8] = mem[data_addr[9:0] + 10'(i)];
    end

    always @(posedge clk) begin
        if (data_wr) begin
            wr_count = wr_count + 1;
            last_wr  = data_out;
            for (int i = 0; i < 4; i++)
                if (({1'b0, data_addr} + 33'(i)) < 33'(MEM_BYTES))
                    mem[data_addr[9:0] + 10'(i)] <= data_out[31-8*i -: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_lat, input int exp_wr,
                           input int hold);
        exp_t e;
        int   lat;
        int   wr0;
        e.tag = tag; e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.nwr = exp_wr;
        sb_q.push_back(e);
        wr0 = wr_count;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        check({e.tag, " latency"}, 32'(lat), 32'(e.lat));
        check({e.tag, " rdata"}, resp_rdata, e.rdata);
        check({e.tag, " err"}, 32'(resp_err), 32'(e.err));
        check({e.tag, " writes"}, 32'(wr_count - wr0), 32'(e.nwr));
        if (hold > 0) begin
            req_valid = 1'b1; req_op = LW; req_addr = 32'h0000_0020;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check({e.tag, " held valid"}, 32'(resp_valid), 32'd1);
                check({e.tag, " held rdata"}, resp_rdata, e.rdata);
                check({e.tag, " busy ready"}, 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({e.tag, " valid dropped"}, 32'(resp_valid), 32'd0);
        check({e.tag, " ready again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        mem['h10] = 8'h80; mem['h11] = 8'h12; mem['h12] = 8'h34; mem['h13] = 8'h56;
        mem['h14] = 8'h9A; mem['h15] = 8'hBC;
        mem['h3FC] = 8'h01; mem['h3FD] = 8'h02; mem['h3FE] = 8'h03; mem['h3FF] = 8'h04;

        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst data_wr", 32'(data_wr), 32'd0);
        check("rst data_addr", data_addr, 32'h0);
        check("rst data_out", data_out, 32'h0);
        rst = 1'b0;
        #1;
        check("idle req_ready", 32'(req_ready), 32'd1);

        run_req("LB 0x10",  LB,  32'h10, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 0);
        run_req("LBU 0x10", LBU, 32'h10, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 0);
        run_req("LH 0x10",  LH,  32'h10, 32'h0, 32'hFFFF_8012, 1'b0, 2, 0, 0);
        run_req("LHU 0x12", LHU, 32'h12, 32'h0, 32'h0000_3456, 1'b0, 2, 0, 0);

        run_req("SB 0x11",  SB,  32'h11, 32'h0000_00AB, 32'h0, 1'b0, 3, 1, 0);
        check("SB 0x11 data_out", last_wr, 32'hAB34_569A);
        run_req("LW 0x10",  LW,  32'h10, 32'h0, 32'h80AB_3456, 1'b0, 2, 0, 0);

`ifdef LSU_ALIGN_CHECK_EN
        run_req("LW 0x12",  LW,  32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run_req("LH 0x15",  LH,  32'h15, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
        run_req("LW 0x12",  LW,  32'h12, 32'h0, 32'h3456_9ABC, 1'b0, 2, 0, 0);
        run_req("LH 0x15",  LH,  32'h15, 32'h0, 32'hFFFF_BC00, 1'b0, 2, 0, 0);
`endif

        run_req("LW 0x3FD", LW,  32'h3FD, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run_req("LW 0x3FC", LW,  32'h3FC, 32'h0, 32'h0102_0304, 1'b0, 2, 0, 0);
        run_req("SH 0x3FF", SH,  32'h3FF, 32'h0000_1234, 32'h0, 1'b1, 1, 0, 0);
        run_req("LW 0xFFFFFFFE", LW, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        run_req("SB 0x3FF", SB,  32'h3FF, 32'h0000_0055, 32'h0, 1'b0, 3, 1, 0);
        check("SB 0x3FF data_out", last_wr, 32'h5500_0000);
        run_req("LBU 0x3FF", LBU, 32'h3FF, 32'h0, 32'h0000_0055, 1'b0, 2, 0, 0);

        run_req("SW 0x20",  SW,  32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 0);
        check("SW 0x20 data_out", last_wr, 32'hDEAD_BEEF);
        run_req("LW 0x20",  LW,  32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 0);

        begin : reset_in_wr
            int wr0;
            wr0 = wr_count;
            @(negedge clk);
            req_valid = 1'b1; req_op = SH; req_addr = 32'h20; req_wdata = 32'h0000_CAFE;
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(posedge clk); #1;
            check("rstWR data_wr before", 32'(data_wr), 32'd1);
            rst = 1'b1;
            #1;
            check("rstWR data_wr gated", 32'(data_wr), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            check("rstWR req_ready", 32'(req_ready), 32'd1);
            check("rstWR resp_valid", 32'(resp_valid), 32'd0);
            check("rstWR writes", 32'(wr_count - wr0), 32'd0);
            check("rstWR mem", {mem['h20], mem['h21], mem['h22], mem['h23]}, 32'hDEAD_BEEF);
        end

        run_req("LB stall", LB, 32'h10, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 5);
        check("stall scoreboard empty", 32'(sb_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
